// File: rtl/syncram_bhw_if.sv
// Request/response channel of the byte/half/word data RAM.
// The CPU side is the master and the RAM is the slave.
interface syncram_bhw_if #(
  parameter int ADDR_W = 32
);
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [1:0]        req_size;
  logic              req_signed;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_wdata;
  logic              rsp_valid;
  logic [31:0]       rsp_rdata;
  logic              rsp_err;

  modport master (
    output req_valid, req_we, req_size, req_signed, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_size, req_signed, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/syncram_bhw.sv
// Single-port word-indexed data RAM with big-endian byte/half/word access and a fixed
// response latency. Define SYNCRAM_ERR_EN to flag misaligned, reserved-size and out-of-range accesses.
module syncram_bhw #(
  parameter string MEM_FILE = "",
  parameter int    DEPTH    = 1024,
  parameter int    ADDR_W   = 32,
  parameter int    LATENCY  = 1
)(
  input  logic          clk,
  input  logic          rst,
  syncram_bhw_if.slave  bus
);
  localparam int IDX_W = $clog2(DEPTH);

  typedef enum logic {IDLE, WAIT} state_e;
  typedef struct packed {
    logic        err;
    logic [31:0] rdata;
  } rsp_t;

  logic [31:0] mem_q [DEPTH];

  state_e state_q, state_d;
  logic [2:0] cnt_q, cnt_d;
  logic [LATENCY-1:0] vld_pipe_q, vld_pipe_d;
  rsp_t [LATENCY-1:0] rsp_pipe_q, rsp_pipe_d;

  logic             accept, err, mem_we;
  logic [IDX_W-1:0] idx;
  logic [1:0]       boff;
  logic [3:0]       be;
  logic [31:0]      word_rd, wrep, wr_word, shifted, ld_data;
  rsp_t             rsp_new;

  initial begin
    for (int i = 0; i < DEPTH; i++) mem_q[i] = '0;
  end

  assign bus.req_ready = (state_q == IDLE) && !rst;
  assign accept        = bus.req_valid && bus.req_ready;
  assign idx           = bus.req_addr[IDX_W+1:2];
  assign boff          = bus.req_addr[1:0];
  assign word_rd       = mem_q[idx];

`ifdef SYNCRAM_ERR_EN
  assign err = (bus.req_size == 2'b01 && bus.req_addr[0])
            || (bus.req_size == 2'b10 && boff != 2'b00)
            || (bus.req_size == 2'b11)
            || (|(bus.req_addr >> (IDX_W + 2)));
`else
  assign err = 1'b0;
`endif

  logic unused_addr;
  assign unused_addr = ^bus.req_addr;

  // be[b] covers byte offset b, which lives at bits [31-8b -: 8] (big-endian)
  always_comb begin
    be   = 4'b1111;
    wrep = bus.req_wdata;
    case (bus.req_size)
      2'b00: begin be = 4'b0001 << boff; wrep = {4{bus.req_wdata[7:0]}}; end
      2'b01: begin be = boff[1] ? 4'b1100 : 4'b0011; wrep = {2{bus.req_wdata[15:0]}}; end
      default: ;
    endcase
  end

  for (genvar b = 0; b < 4; b++) begin : g_lane
    assign wr_word[31-8*b -: 8] = be[b] ? wrep[31-8*b -: 8] : word_rd[31-8*b -: 8];
  end

  assign mem_we = accept && bus.req_we && !err;

  always_ff @(posedge clk) begin
    if (mem_we) mem_q[idx] <= wr_word;
  end

  // Shift the addressed lane up to the MSBs so extension always reads bit 31
  always_comb begin
    shifted = word_rd;
    ld_data = word_rd;
    case (bus.req_size)
      2'b00: begin
        shifted = word_rd << {boff, 3'b000};
        ld_data = {{24{bus.req_signed & shifted[31]}}, shifted[31:24]};
      end
      2'b01: begin
        shifted = word_rd << {boff[1], 4'b0000};
        ld_data = {{16{bus.req_signed & shifted[31]}}, shifted[31:16]};
      end
      default: ;
    endcase
  end

  always_comb begin
    rsp_new.err   = err;
    rsp_new.rdata = (bus.req_we || err) ? 32'h0 : ld_data;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: if (accept && LATENCY > 1) begin
        state_d = WAIT;
        cnt_d   = 3'(LATENCY - 1);
      end
      WAIT: if (cnt_q == 3'd1) state_d = IDLE;
            else cnt_d = cnt_q - 3'd1;
      default: state_d = IDLE;
    endcase
  end

  // Data stages only load on a valid, so the last stage holds between responses
  always_comb begin
    vld_pipe_d    = '0;
    rsp_pipe_d    = rsp_pipe_q;
    vld_pipe_d[0] = accept;
    if (accept) rsp_pipe_d[0] = rsp_new;
    for (int i = 1; i < LATENCY; i++) begin
      vld_pipe_d[i] = vld_pipe_q[i-1];
      if (vld_pipe_q[i-1]) rsp_pipe_d[i] = rsp_pipe_q[i-1];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      vld_pipe_q <= '0;
      rsp_pipe_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      vld_pipe_q <= vld_pipe_d;
      rsp_pipe_q <= rsp_pipe_d;
    end
  end

  assign bus.rsp_valid = vld_pipe_q[LATENCY-1];
  assign bus.rsp_rdata = rsp_pipe_q[LATENCY-1].rdata;
  assign bus.rsp_err   = rsp_pipe_q[LATENCY-1].err;
endmodule

// File: tb/tb_syncram_bhw.sv
// Directed bench for syncram_bhw: three instances (LATENCY 1, 3, 4) share one stimulus
// bus and are selected with sel; expectations depend on SYNCRAM_ERR_EN.
module tb_syncram_bhw;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;
  int sel    = 1;

  logic        t_valid = 1'b0, t_we = 1'b0, t_sgn = 1'b0;
  logic [1:0]  t_size = 2'b10;
  logic [31:0] t_addr = '0, t_wdata = '0;

  syncram_bhw_if #(.ADDR_W(32)) if1 ();
  syncram_bhw_if #(.ADDR_W(32)) if3 ();
  syncram_bhw_if #(.ADDR_W(32)) if4 ();

  assign if1.req_valid = t_valid && sel == 1;
  assign if3.req_valid = t_valid && sel == 3;
  assign if4.req_valid = t_valid && sel == 4;
  assign {if1.req_we, if1.req_size, if1.req_signed, if1.req_addr, if1.req_wdata} = {t_we, t_size, t_sgn, t_addr, t_wdata};
  assign {if3.req_we, if3.req_size, if3.req_signed, if3.req_addr, if3.req_wdata} = {t_we, t_size, t_sgn, t_addr, t_wdata};
  assign {if4.req_we, if4.req_size, if4.req_signed, if4.req_addr, if4.req_wdata} = {t_we, t_size, t_sgn, t_addr, t_wdata};

  syncram_bhw #(.DEPTH(1024), .ADDR_W(32), .LATENCY(1)) u_l1 (.clk(clk), .rst(rst), .bus(if1));
  syncram_bhw #(.DEPTH(1024), .ADDR_W(32), .LATENCY(3)) u_l3 (.clk(clk), .rst(rst), .bus(if3));
  syncram_bhw #(.DEPTH(1024), .ADDR_W(32), .LATENCY(4)) u_l4 (.clk(clk), .rst(rst), .bus(if4));

  logic        c_ready, c_rvld, c_err;
  logic [31:0] c_rdata;
  always_comb begin
    c_ready = if1.req_ready; c_rvld = if1.rsp_valid; c_rdata = if1.rsp_rdata; c_err = if1.rsp_err;
    if (sel == 3) begin
      c_ready = if3.req_ready; c_rvld = if3.rsp_valid; c_rdata = if3.rsp_rdata; c_err = if3.rsp_err;
    end else if (sel == 4) begin
      c_ready = if4.req_ready; c_rvld = if4.rsp_valid; c_rdata = if4.rsp_rdata; c_err = if4.rsp_err;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // One request; lat = negedges from accept until rsp_valid is seen (20 = never came)
  task automatic xact(input logic we, input logic [1:0] sz, input logic sg,
                      input logic [31:0] a, input logic [31:0] wd,
                      output logic [31:0] rd, output logic e, output int lat);
    int n;
    @(negedge clk);
    t_we = we; t_size = sz; t_sgn = sg; t_addr = a; t_wdata = wd; t_valid = 1'b1;
    n = 0;
    while (!c_ready && n < 20) begin @(negedge clk); n++; end
    @(posedge clk);
    @(negedge clk);
    t_valid = 1'b0;
    lat = 1;
    while (!c_rvld && lat < 20) begin @(negedge clk); lat++; end
    rd = c_rdata; e = c_err;
  endtask

  logic [31:0] rd;
  logic        e;
  int          lat;
  logic [8:0]  rdy_pat, rsp_pat;
  int          cnt;

  initial begin
    // reset held with a store pending on the L1 instance
    sel = 1; t_valid = 1'b1; t_we = 1'b1; t_size = 2'b10; t_addr = 32'h0; t_wdata = 32'hCAFEF00D;
    @(posedge clk);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rst_ready", {31'b0, c_ready}, 32'd0);
      chk("rst_rvld",  {31'b0, c_rvld},  32'd0);
    end
    rst = 1'b0; t_valid = 1'b0;
    @(negedge clk);
    chk("rel_ready", {31'b0, c_ready}, 32'd1);
    xact(0, 2'b10, 0, 32'h0, 0, rd, e, lat);
    chk("rst_nowrite", rd, 32'h0);

    // lanes
    xact(1, 2'b10, 0, 32'h10, 32'h11223344, rd, e, lat);
    chk("sw_rdata", rd, 32'h0);
    chk("sw_lat1", lat, 1);
    xact(0, 2'b00, 0, 32'h11, 0, rd, e, lat);
    chk("lbu_11", rd, 32'h00000022);
    xact(1, 2'b00, 0, 32'h12, 32'h000000AB, rd, e, lat);
    xact(0, 2'b10, 0, 32'h10, 0, rd, e, lat);
    chk("lw_after_sb", rd, 32'h1122AB44);

    // extension
    xact(1, 2'b01, 0, 32'h20, 32'h00008001, rd, e, lat);
    xact(0, 2'b01, 1, 32'h20, 0, rd, e, lat);
    chk("lh_s", rd, 32'hFFFF8001);
    xact(0, 2'b01, 0, 32'h20, 0, rd, e, lat);
    chk("lh_u", rd, 32'h00008001);
    xact(0, 2'b00, 1, 32'h21, 0, rd, e, lat);
    chk("lb_s_21", rd, 32'h00000001);
    xact(0, 2'b00, 1, 32'h20, 0, rd, e, lat);
    chk("lb_s_20", rd, 32'hFFFFFF80);
    xact(0, 2'b01, 0, 32'h12, 0, rd, e, lat);
    chk("lhu_12", rd, 32'h0000AB44);

    // L1 back-to-back: ready always high, a response every cycle after the first
    @(negedge clk);
    t_we = 0; t_size = 2'b10; t_addr = 32'h10; t_valid = 1'b1;
    for (int j = 0; j < 4; j++) begin
      if (j > 0) @(negedge clk);
      rdy_pat[j] = c_ready; rsp_pat[j] = c_rvld;
    end
    t_valid = 1'b0;
    chk("l1_rdy_pat", {28'b0, rdy_pat[3:0]}, 32'hF);
    chk("l1_rsp_pat", {28'b0, rsp_pat[3:0]}, 32'hE);

    // L3: latency and throughput
    sel = 3;
    xact(1, 2'b10, 0, 32'h10, 32'h0BADF00D, rd, e, lat);
    chk("l3_lat", lat, 3);
    @(negedge clk);
    t_we = 0; t_size = 2'b10; t_addr = 32'h10; t_valid = 1'b1;
    for (int j = 0; j < 9; j++) begin
      if (j > 0) @(negedge clk);
      rdy_pat[j] = c_ready; rsp_pat[j] = c_rvld;
    end
    @(negedge clk);
    t_valid = 1'b0;
    chk("l3_rdy_pat", {23'b0, rdy_pat}, 32'h049);
    chk("l3_rsp_pat", {23'b0, rsp_pat}, 32'h048);
    chk("l3_last_rsp", {31'b0, c_rvld}, 32'd1);
    chk("l3_rdata", c_rdata, 32'h0BADF00D);

    // L4: reset one cycle after a store is accepted
    sel = 4;
    @(negedge clk);
    t_we = 1; t_size = 2'b10; t_addr = 32'h40; t_wdata = 32'hDEADBEEF; t_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    t_valid = 1'b0; rst = 1'b1;
    cnt = 0;
    for (int j = 0; j < 6; j++) begin
      @(negedge clk);
      rst = 1'b0;
      if (c_rvld) cnt++;
    end
    chk("abort_norsp", cnt, 0);
    xact(0, 2'b10, 0, 32'h40, 0, rd, e, lat);
    chk("abort_kept", rd, 32'hDEADBEEF);
    chk("l4_lat", lat, 4);

    // errors / alignment
    xact(0, 2'b10, 0, 32'h42, 0, rd, e, lat);
`ifdef SYNCRAM_ERR_EN
    chk("mis_lw_err", {31'b0, e}, 32'd1);
    chk("mis_lw_rd", rd, 32'h0);
`else
    chk("mis_lw_err", {31'b0, e}, 32'd0);
    chk("mis_lw_rd", rd, 32'hDEADBEEF);
`endif
    xact(1, 2'b10, 0, 32'h1000, 32'h55555555, rd, e, lat);
    xact(0, 2'b10, 0, 32'h0, 0, rd, e, lat);
`ifdef SYNCRAM_ERR_EN
    chk("oob_w0", rd, 32'h0);
`else
    chk("wrap_w0", rd, 32'h55555555);
`endif
    xact(0, 2'b11, 0, 32'h40, 0, rd, e, lat);
`ifdef SYNCRAM_ERR_EN
    chk("sz11_err", {31'b0, e}, 32'd1);
    chk("sz11_rd", rd, 32'h0);
`else
    chk("sz11_err", {31'b0, e}, 32'd0);
    chk("sz11_rd", rd, 32'hDEADBEEF);
`endif
    xact(0, 2'b00, 0, 32'h43, 0, rd, e, lat);
    chk("lbu_43_ok", {e, rd[30:0]}, 32'h000000EF);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
